// File: rtl/writeback_pc_unit_if.sv
// Handshake and data bus of the write-back / next-PC stage.
// master: the side that issues retiring instructions and UART receive data.
// slave:  the writeback_pc_unit itself.
interface writeback_pc_unit_if #(
    parameter int INST_MEM_WIDTH = 14,
    parameter int DATA_WIDTH     = 32
);
    // retiring instruction
    logic                      in_valid;
    logic                      in_ready;
    logic                      RegWrite;
    logic [1:0]                MemtoReg;
    logic                      UARTtoReg;
    logic [2:0]                Branch;
    logic [DATA_WIDTH-1:0]     read_data;
    logic [DATA_WIDTH-1:0]     register_data;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [4:0]                rd;
    logic [25:0]               inst_index;
    logic [INST_MEM_WIDTH-1:0] pc;
    logic [INST_MEM_WIDTH-1:0] pc2;
    // UART receive
    logic                      uart_rx_valid;
    logic [DATA_WIDTH-1:0]     uart_rx_data;
    logic                      uart_rx_ready;
    // results
    logic                      out_valid;
    logic                      RegWrite_next;
    logic [4:0]                rd_next;
    logic [DATA_WIDTH-1:0]     data;
    logic                      UART_write_enable;
    logic [INST_MEM_WIDTH-1:0] pc_generated;
    logic                      ras_empty;

    modport master (
        output in_valid, RegWrite, MemtoReg, UARTtoReg, Branch,
               read_data, register_data, alu_result, rd, inst_index, pc, pc2,
               uart_rx_valid, uart_rx_data,
        input  in_ready, uart_rx_ready, out_valid, RegWrite_next, rd_next, data,
               UART_write_enable, pc_generated, ras_empty
    );

    modport slave (
        input  in_valid, RegWrite, MemtoReg, UARTtoReg, Branch,
               read_data, register_data, alu_result, rd, inst_index, pc, pc2,
               uart_rx_valid, uart_rx_data,
        output in_ready, uart_rx_ready, out_valid, RegWrite_next, rd_next, data,
               UART_write_enable, pc_generated, ras_empty
    );
endinterface

// File: rtl/writeback_pc_unit.sv
// writeback_pc_unit: registered write-back source select and next-PC
// computation for one retiring instruction per cycle. Instructions that read
// the UART stall in WAIT_RX until receive data arrives.
// Optional feature macro: WRITEBACK_PC_RAS_EN builds a return-address stack
// used by Branch 100 (call, push) and 110 (return, pop). Without it, 100 acts
// as a plain jump and 110 as a register jump, and ras_empty is tied high.
module writeback_pc_unit #(
    parameter int INST_MEM_WIDTH = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int RAS_DEPTH      = 4
) (
    input logic               clk,
    input logic               rstn,
    writeback_pc_unit_if.slave bus
);
    localparam int IW = INST_MEM_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        WAIT_RX = 1'b1
    } state_t;

    state_t          state_r;

    // instruction held while waiting for UART data
    logic            lat_rw_r;
    logic [1:0]      lat_m2r_r;
    logic [2:0]      lat_br_r;
    logic [DW-1:0]   lat_rdata_r;
    logic [DW-1:0]   lat_regd_r;
    logic [DW-1:0]   lat_alu_r;
    logic [4:0]      lat_rd_r;
    logic [IW-1:0]   lat_idx_r;
    logic [IW-1:0]   lat_pc_r;
    logic [IW-1:0]   lat_pc2_r;

    // instruction being completed this cycle (bus or latched copy)
    logic            sel_rw_s;
    logic [1:0]      sel_m2r_s;
    logic            sel_u2r_s;
    logic [2:0]      sel_br_s;
    logic [DW-1:0]   sel_rdata_s;
    logic [DW-1:0]   sel_regd_s;
    logic [DW-1:0]   sel_alu_s;
    logic [4:0]      sel_rd_s;
    logic [IW-1:0]   sel_idx_s;
    logic [IW-1:0]   sel_pc_s;
    logic [IW-1:0]   sel_pc2_s;

    logic            accept_s;
    logic            complete_s;
    logic [IW-1:0]   pc1_s;
    logic [IW-1:0]   ret_target_s;
    logic [IW-1:0]   next_pc_s;
    logic [DW-1:0]   wb_data_s;

    logic            out_valid_r;
    logic            reg_write_r;
    logic [4:0]      rd_next_r;
    logic [DW-1:0]   data_r;
    logic            uart_we_r;
    logic [IW-1:0]   pc_gen_r;

    // upper jump-field bits lie outside the instruction memory
    logic            unused_idx_s;
    assign unused_idx_s = ^bus.inst_index[25:IW];

    assign accept_s          = bus.in_valid && (state_r == RUN);
    assign bus.in_ready      = (state_r == RUN);
    assign bus.uart_rx_ready = (state_r == WAIT_RX) || (accept_s && bus.UARTtoReg);

    // Stage state and capture of a stalled UART-read instruction
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= RUN;
            lat_rw_r    <= 1'b0;
            lat_m2r_r   <= 2'b00;
            lat_br_r    <= 3'b000;
            lat_rdata_r <= {DW{1'b0}};
            lat_regd_r  <= {DW{1'b0}};
            lat_alu_r   <= {DW{1'b0}};
            lat_rd_r    <= 5'd0;
            lat_idx_r   <= {IW{1'b0}};
            lat_pc_r    <= {IW{1'b0}};
            lat_pc2_r   <= {IW{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (accept_s && bus.UARTtoReg && !bus.uart_rx_valid) begin
                        state_r     <= WAIT_RX;
                        lat_rw_r    <= bus.RegWrite;
                        lat_m2r_r   <= bus.MemtoReg;
                        lat_br_r    <= bus.Branch;
                        lat_rdata_r <= bus.read_data;
                        lat_regd_r  <= bus.register_data;
                        lat_alu_r   <= bus.alu_result;
                        lat_rd_r    <= bus.rd;
                        lat_idx_r   <= bus.inst_index[IW-1:0];
                        lat_pc_r    <= bus.pc;
                        lat_pc2_r   <= bus.pc2;
                    end
                end
                WAIT_RX: begin
                    if (bus.uart_rx_valid) begin
                        state_r <= RUN;
                    end
                end
                default: state_r <= RUN;
            endcase
        end
    end

    // Pick the live bus fields in RUN, the captured copy in WAIT_RX
    always_comb begin
        if (state_r == WAIT_RX) begin
            sel_rw_s    = lat_rw_r;
            sel_m2r_s   = lat_m2r_r;
            sel_u2r_s   = 1'b1;
            sel_br_s    = lat_br_r;
            sel_rdata_s = lat_rdata_r;
            sel_regd_s  = lat_regd_r;
            sel_alu_s   = lat_alu_r;
            sel_rd_s    = lat_rd_r;
            sel_idx_s   = lat_idx_r;
            sel_pc_s    = lat_pc_r;
            sel_pc2_s   = lat_pc2_r;
        end else begin
            sel_rw_s    = bus.RegWrite;
            sel_m2r_s   = bus.MemtoReg;
            sel_u2r_s   = bus.UARTtoReg;
            sel_br_s    = bus.Branch;
            sel_rdata_s = bus.read_data;
            sel_regd_s  = bus.register_data;
            sel_alu_s   = bus.alu_result;
            sel_rd_s    = bus.rd;
            sel_idx_s   = bus.inst_index[IW-1:0];
            sel_pc_s    = bus.pc;
            sel_pc2_s   = bus.pc2;
        end
    end

    // An instruction completes once it no longer needs UART data
    always_comb begin
        complete_s = 1'b0;
        if (state_r == WAIT_RX) begin
            complete_s = bus.uart_rx_valid;
        end else if (accept_s) begin
            complete_s = !bus.UARTtoReg || bus.uart_rx_valid;
        end else begin
            complete_s = 1'b0;
        end
    end

    // pc+1 wraps naturally at the address width
    assign pc1_s = sel_pc_s + IW'(1);

    // Write-back source select; UART receive data overrides MemtoReg
    always_comb begin
        wb_data_s = sel_alu_s;
        if (sel_u2r_s) begin
            wb_data_s = bus.uart_rx_data;
        end else begin
            case (sel_m2r_s)
                2'b00:   wb_data_s = sel_alu_s;
                2'b01:   wb_data_s = sel_rdata_s;
                2'b10:   wb_data_s = {{(DW-IW){1'b0}}, pc1_s};
                2'b11:   wb_data_s = sel_regd_s;
                default: wb_data_s = sel_alu_s;
            endcase
        end
    end

    // Next-PC mode decode
    always_comb begin
        next_pc_s = pc1_s;
        case (sel_br_s)
            3'b000:  next_pc_s = pc1_s;
            3'b001:  next_pc_s = (sel_alu_s == {DW{1'b0}}) ? sel_pc2_s : pc1_s;
            3'b010:  next_pc_s = (sel_alu_s != {DW{1'b0}}) ? sel_pc2_s : pc1_s;
            3'b011:  next_pc_s = sel_idx_s;
            3'b100:  next_pc_s = sel_idx_s;
            3'b101:  next_pc_s = sel_regd_s[IW-1:0];
            3'b110:  next_pc_s = ret_target_s;
            3'b111:  next_pc_s = pc1_s;
            default: next_pc_s = pc1_s;
        endcase
    end

`ifdef WRITEBACK_PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [IW-1:0] ras_mem_r [RAS_DEPTH];
    logic [PW-1:0] ras_ptr_r;     // next slot to write; top is ptr-1
    logic [CW-1:0] ras_cnt_r;
    logic          ras_empty_r;
    logic          push_s;
    logic          pop_s;
    logic [IW-1:0] ras_top_s;

    assign ras_top_s     = ras_mem_r[ras_ptr_r - PW'(1)];
    assign push_s        = complete_s && (sel_br_s == 3'b100);
    assign pop_s         = complete_s && (sel_br_s == 3'b110) && (ras_cnt_r != CW'(0));
    assign ret_target_s  = (ras_cnt_r != CW'(0)) ? ras_top_s : sel_regd_s[IW-1:0];
    assign bus.ras_empty = ras_empty_r;

    // Circular return-address stack; a push when full overwrites the oldest
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= {IW{1'b0}};
            end
            ras_ptr_r   <= {PW{1'b0}};
            ras_cnt_r   <= {CW{1'b0}};
            ras_empty_r <= 1'b1;
        end else if (push_s) begin
            ras_mem_r[ras_ptr_r] <= pc1_s;
            ras_ptr_r            <= ras_ptr_r + PW'(1);
            ras_cnt_r            <= (ras_cnt_r == CW'(RAS_DEPTH)) ? ras_cnt_r : ras_cnt_r + CW'(1);
            ras_empty_r          <= 1'b0;
        end else if (pop_s) begin
            ras_ptr_r   <= ras_ptr_r - PW'(1);
            ras_cnt_r   <= ras_cnt_r - CW'(1);
            ras_empty_r <= (ras_cnt_r == CW'(1));
        end else begin
            ras_ptr_r   <= ras_ptr_r;
            ras_cnt_r   <= ras_cnt_r;
            ras_empty_r <= ras_empty_r;
        end
    end
`else
    localparam int unused_ras_depth = RAS_DEPTH;

    assign ret_target_s  = sel_regd_s[IW-1:0];
    assign bus.ras_empty = 1'b1;
`endif

    // Result registers: strobes pulse with out_valid, data fields hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
            reg_write_r <= 1'b0;
            uart_we_r   <= 1'b0;
            rd_next_r   <= 5'd0;
            data_r      <= {DW{1'b0}};
            pc_gen_r    <= {IW{1'b0}};
        end else if (complete_s) begin
            out_valid_r <= 1'b1;
            reg_write_r <= sel_rw_s && (sel_m2r_s != 2'b11);
            uart_we_r   <= (sel_m2r_s == 2'b11);
            rd_next_r   <= sel_rd_s;
            data_r      <= wb_data_s;
            pc_gen_r    <= next_pc_s;
        end else begin
            out_valid_r <= 1'b0;
            reg_write_r <= 1'b0;
            uart_we_r   <= 1'b0;
        end
    end

    assign bus.out_valid         = out_valid_r;
    assign bus.RegWrite_next     = reg_write_r;
    assign bus.UART_write_enable = uart_we_r;
    assign bus.rd_next           = rd_next_r;
    assign bus.data              = data_r;
    assign bus.pc_generated      = pc_gen_r;
endmodule

// File: doc/writeback_pc_unit.md
# writeback_pc_unit

Registered write-back and next-PC stage for the core, the parametrised successor of the combinational write-back/PC mux. It accepts one retiring instruction per cycle over a valid/ready handshake and selects the register write-back source. It stalls on UART receive data when the instruction reads the UART, and computes the next PC from seven branch modes. An optional return-address stack (RAS) serves call/return.

## Interface
- INST_MEM_WIDTH, 14: PC / instruction-memory address width.
- DATA_WIDTH, 32: data path width.
- RAS_DEPTH, 4: return-address stack entries (power of two, ≥2).

- clk  in  1  core clock.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  retiring instruction present.
- in_ready  out  1  stage accepts this cycle.
- RegWrite  in  1  instruction writes rd.
- MemtoReg  in  2  write-back source: 00 alu_result, 01 read_data, 10 link (pc+1), 11 UART transmit of register_data.
- UARTtoReg  in  1  write-back data comes from UART receive (overrides MemtoReg).
- Branch  in  3  PC mode, see Operation.
- read_data, register_data, alu_result  in  DATA_WIDTH each  candidate sources.
- rd  in  5  destination register.
- inst_index  in  26  jump target field.
- pc  in  INST_MEM_WIDTH  PC of the retiring instruction.
- pc2  in  INST_MEM_WIDTH  conditional-branch target.
- uart_rx_valid  in  1 / uart_rx_data  in  DATA_WIDTH / uart_rx_ready  out  1  receive handshake.
- out_valid  out  1  write-back/PC result valid (one-cycle pulse).
- RegWrite_next  out  1 / rd_next  out  5 / data  out  DATA_WIDTH  register-file write.
- UART_write_enable  out  1  transmit strobe; data carries the byte word.
- pc_generated  out  INST_MEM_WIDTH  next PC.
- ras_empty  out  1  RAS holds no entries.

## Operation
- States: RUN, WAIT_RX. Reset → RUN.
- in_ready = (state==RUN). An accept is in_valid && in_ready.
- Accept with UARTtoReg=0: results registered, out_valid=1 next cycle.
- Accept with UARTtoReg=1:
  - If uart_rx_valid is high the same cycle: consume and complete as above.
  - Otherwise latch all fields and enter WAIT_RX.
- uart_rx_ready is high only in RUN with an accepting UARTtoReg instruction, or in WAIT_RX.
- WAIT_RX: on uart_rx_valid, consume, complete, return to RUN.
- Write-back:
  - data = uart_rx_data if UARTtoReg, else the MemtoReg source. The link value is pc+1 zero-extended.
  - RegWrite_next = RegWrite && MemtoReg!=11.
  - UART_write_enable = (MemtoReg==11), data = register_data.
- pc1 = pc+1 modulo 2^INST_MEM_WIDTH; all-ones wraps to 0.
- Branch modes:
  - 000: pc1.
  - 001: pc2 if alu_result==0, else pc1.
  - 010: pc2 if alu_result!=0, else pc1.
  - 011: inst_index[INST_MEM_WIDTH-1:0].
  - 100: call; same target as 011, push pc1 onto the RAS.
  - 101: register_data[INST_MEM_WIDTH-1:0].
  - 110: return; see Configuration.
  - 111: reserved; pc1.
- RAS:
  - Circular buffer with a saturating count.
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop when empty uses register_data and leaves the RAS unchanged.

## Timing
- Latency: accept at cycle N → outputs valid in cycle N+1 for one cycle. With a UART stall, outputs are valid the cycle after uart_rx_valid is seen.
- Outputs are registered. Outside out_valid, RegWrite_next and UART_write_enable are 0; data, rd_next and pc_generated hold their last values.
- Reset values: all outputs 0 except in_ready=1 and ras_empty=1. The RAS count is 0 and the state is RUN.
- Asserting rstn low mid-WAIT_RX discards the latched instruction. No out_valid is produced for it.
- Back-to-back accepts give one out_valid per cycle. RAS push/pop is applied at accept or completion, so the next instruction sees the updated stack.

## Configuration
- WRITEBACK_PC_RAS_EN defined: RAS built; Branch 110 pops the top entry, or uses register_data if empty.
- Undefined: no RAS storage; 110 behaves as 101, 100 behaves as 011 without push, ras_empty tied to 1.

## Test plan
- MemtoReg 00/01/10 with alu_result=32'h11111111, read_data=32'hffffffff, pc=14'h2, RegWrite=1, rd=28 → data 11111111, ffffffff, 00000003 on successive cycles; rd_next=28.
- MemtoReg=11, register_data=32'haaaaaaaa → UART_write_enable=1, data=aaaaaaaa, RegWrite_next=0.
- UARTtoReg=1, uart_rx_valid low for 3 cycles then high with 32'h55555555 → in_ready=0 for 3 cycles, out_valid the next cycle, data=55555555.
- Branch 001, alu_result=0, pc2=14'h100 → pc_generated=100; alu_result=1 → pc+1. pc=14'h3fff, Branch 000 → 0.
- With WRITEBACK_PC_RAS_EN: calls from pc=10,20,30 then three returns → 31,21,11. A fourth return uses register_data. RAS_DEPTH+1 pushes drop the oldest entry.
- Reset asserted during WAIT_RX → no out_valid; outputs 0, in_ready=1.
